// File: rtl/mem_rr_arbiter_pkg.sv
// Shared types and helpers for the demo memory-port arbiter.
package mem_rr_arbiter_pkg;

  localparam int MAX_REQ = 8;

  // One requester's view of a memory request.
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_req_t;

  // Downstream response bundle.
  typedef struct packed {
    logic        rvalid;
    logic        err;
    logic [31:0] rdata;
  } mem_rsp_t;

  // Requester index width; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_rr_arbiter_rr_arb.sv
// Combinational round-robin picker: the first requester at or after prio wins.
module rr_arb
  import mem_rr_arbiter_pkg::*;
#(
  parameter int  N  = 2,
  localparam int IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] prio,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan offsets from farthest to nearest so the nearest requester overwrites idx.
  always_comb begin
    int cand;
    cand = 0;
    idx  = '0;
    any  = |req;
    for (int k = N - 1; k >= 0; k--) begin
      cand = int'(prio) + k;
      cand = (cand >= N) ? (cand - N) : cand;
      if (req[cand]) begin
        idx = IW'(cand);
      end else begin
        idx = idx;
      end
    end
  end

  // Expand the winner index into a one-hot grant.
  always_comb begin
    gnt = '0;
    for (int i = 0; i < N; i++) begin
      gnt[i] = any && (idx == IW'(i));
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin sharing of one fixed-latency memory port between NUM_REQ requesters,
// with in-flight ownership tracking so each response returns to its issuer.
module mem_rr_arbiter
  import mem_rr_arbiter_pkg::*;
#(
  parameter int  NUM_REQ  = 2,
  parameter int  RESP_LAT = 1,
  localparam int ID_W     = id_width(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [NUM_REQ*32-1:0]  addr_i,
  input  logic [NUM_REQ-1:0]     we_i,
  input  logic [NUM_REQ*4-1:0]   be_i,
  input  logic [NUM_REQ*32-1:0]  wdata_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  output logic [NUM_REQ-1:0]     rvalid_o,
  output logic [31:0]            rdata_o,
  output logic [NUM_REQ-1:0]     err_o,
  output logic                   mem_req_o,
  output logic [31:0]            mem_addr_o,
  output logic                   mem_we_o,
  output logic [3:0]             mem_be_o,
  output logic [31:0]            mem_wdata_o,
  input  logic                   mem_rvalid_i,
  input  logic                   mem_err_i,
  input  logic [31:0]            mem_rdata_i,
  output logic                   spurious_o
);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("mem_rr_arbiter: NUM_REQ out of range");
  end

  logic [NUM_REQ-1:0] gnt_s;
  logic [ID_W-1:0]    winner_s;
  logic               any_s;
  logic [ID_W-1:0]    prio_r;
  logic [ID_W-1:0]    prio_nxt_s;
  mem_req_t           req_bus_s [NUM_REQ];
  mem_req_t           sel_s;
  mem_rsp_t           rsp_s;
  logic [RESP_LAT-1:0] vld_r;
  logic [ID_W-1:0]    id_r [RESP_LAT];

  rr_arb #(.N(NUM_REQ)) u_arb (
    .req  (req_i),
    .prio (prio_r),
    .gnt  (gnt_s),
    .idx  (winner_s),
    .any  (any_s)
  );

  assign gnt_o     = gnt_s;
  assign mem_req_o = any_s;

  // Unpack the flat per-requester buses into request structs.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_bus_s[i].addr  = addr_i[i*32 +: 32];
      req_bus_s[i].we    = we_i[i];
      req_bus_s[i].be    = be_i[i*4 +: 4];
      req_bus_s[i].wdata = wdata_i[i*32 +: 32];
    end
  end

  // Forward the winner's request downstream; an idle port presents all zeros.
  always_comb begin
    sel_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (any_s && (winner_s == ID_W'(i))) begin
        sel_s = req_bus_s[i];
      end else begin
        sel_s = sel_s;
      end
    end
  end

  assign mem_addr_o  = sel_s.addr;
  assign mem_we_o    = sel_s.we;
  assign mem_be_o    = sel_s.be;
  assign mem_wdata_o = sel_s.wdata;

  // Priority moves just past the winner, wrapping explicitly for any NUM_REQ.
  always_comb begin
    prio_nxt_s = (winner_s == ID_W'(NUM_REQ - 1)) ? '0 : (winner_s + ID_W'(1));
  end

  // Round-robin pointer: advances only when something was granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_r <= '0;
    end else if (any_s) begin
      prio_r <= prio_nxt_s;
    end else begin
      prio_r <= prio_r;
    end
  end

  // Ownership pipeline: one stage per cycle of downstream latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r <= '0;
      for (int k = 0; k < RESP_LAT; k++) begin
        id_r[k] <= '0;
      end
    end else begin
      vld_r[0] <= any_s;
      id_r[0]  <= winner_s;
      for (int k = 1; k < RESP_LAT; k++) begin
        vld_r[k] <= vld_r[k-1];
        id_r[k]  <= id_r[k-1];
      end
    end
  end

  assign rsp_s.rvalid = mem_rvalid_i;
  assign rsp_s.err    = mem_err_i;
  assign rsp_s.rdata  = mem_rdata_i;
  assign rdata_o      = rsp_s.rdata;

  // Route the response to the tail owner; a missing response becomes an error,
  // and a response nobody is waiting for is dropped and flagged.
  always_comb begin
    rvalid_o   = '0;
    err_o      = '0;
    spurious_o = 1'b0;
    if (vld_r[RESP_LAT-1]) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (id_r[RESP_LAT-1] == ID_W'(i)) begin
          rvalid_o[i] = 1'b1;
          err_o[i]    = rsp_s.rvalid ? rsp_s.err : 1'b1;
        end else begin
          rvalid_o[i] = 1'b0;
          err_o[i]    = 1'b0;
        end
      end
    end else begin
      spurious_o = rsp_s.rvalid;
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Self-checking bench for mem_rr_arbiter with NUM_REQ=3, RESP_LAT=3.
module tb_mem_rr_arbiter;

  localparam int NUM_REQ  = 3;
  localparam int RESP_LAT = 3;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_i, we_i, gnt_o, rvalid_o, err_o;
  logic [NUM_REQ*32-1:0] addr_i, wdata_i;
  logic [NUM_REQ*4-1:0]  be_i;
  logic [31:0]           rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic                  mem_req_o, mem_we_o, mem_rvalid_i, mem_err_i, spurious_o;
  logic [3:0]            mem_be_o;

  mem_rr_arbiter #(.NUM_REQ(NUM_REQ), .RESP_LAT(RESP_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
    .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o), .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i),
    .mem_err_i(mem_err_i), .mem_rdata_i(mem_rdata_i), .spurious_o(spurious_o)
  );

  always #5 clk = ~clk;

  typedef struct { int id; int due; } trk_t;
  typedef struct { int due; bit drop; logic err; logic [31:0] data; } rsp_t;

  trk_t trk_q[$];   // model: accepted requests awaiting their response slot
  rsp_t mem_q[$];   // memory stub: responses it will return
  int   cyc, prio_m, n_cmp, n_mis;
  bit   drop_next, force_spur;

  int                 exp_win;
  logic [NUM_REQ-1:0] exp_gnt, exp_rvalid, exp_err, last_gnt;
  logic               exp_spur, exp_mreq, exp_we;
  logic [31:0]        exp_addr, exp_wdata;
  logic [3:0]         exp_be;

  task automatic drive_mem();
    while (mem_q.size() > 0 && mem_q[0].due < cyc) void'(mem_q.pop_front());
    mem_rdata_i  = $urandom;
    mem_err_i    = 1'($urandom_range(0, 1));
    mem_rvalid_i = 1'b0;
    if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
      mem_rvalid_i = !mem_q[0].drop;
      mem_err_i    = mem_q[0].err;
      mem_rdata_i  = mem_q[0].data;
    end else begin
      mem_rvalid_i = force_spur;
    end
  endtask

  // Reference: round-robin from prio_m, responses owned by the oldest due entry.
  task automatic model_eval();
    int c;
    exp_win = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = (prio_m + k) % NUM_REQ;
      if (req_i[c] && exp_win < 0) exp_win = c;
    end
    exp_gnt = '0; exp_mreq = 1'b0; exp_addr = '0; exp_we = 1'b0; exp_be = '0; exp_wdata = '0;
    if (exp_win >= 0) begin
      exp_gnt[exp_win] = 1'b1;
      exp_mreq  = 1'b1;
      exp_addr  = addr_i[exp_win*32 +: 32];
      exp_we    = we_i[exp_win];
      exp_be    = be_i[exp_win*4 +: 4];
      exp_wdata = wdata_i[exp_win*32 +: 32];
    end
    exp_rvalid = '0; exp_err = '0; exp_spur = 1'b0;
    if (trk_q.size() > 0 && trk_q[0].due == cyc) begin
      exp_rvalid[trk_q[0].id] = 1'b1;
      exp_err[trk_q[0].id]    = mem_rvalid_i ? mem_err_i : 1'b1;
    end else begin
      exp_spur = mem_rvalid_i;
    end
  endtask

  task automatic settle();
    drive_mem();
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n && exp_win >= 0) begin
      prio_m = (exp_win + 1) % NUM_REQ;
      trk_q.push_back('{exp_win, cyc + RESP_LAT});
      mem_q.push_back('{cyc + RESP_LAT, drop_next, 1'($urandom_range(0, 3) == 0), $urandom});
    end
    drop_next = 1'b0;
    force_spur = 1'b0;
    if (trk_q.size() > 0 && trk_q[0].due == cyc) void'(trk_q.pop_front());
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic w);
    req_i[i] = 1'b1;
    addr_i[i*32 +: 32] = a;
    we_i[i] = w;
    be_i[i*4 +: 4] = 4'hF;
    wdata_i[i*32 +: 32] = $urandom;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    req_i = '0;
    trk_q.delete();
    prio_m = 0;
    repeat (n) begin settle(); tick(); end
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(2);
    req_i = '0;
    settle();
    n_cmp++; if (rvalid_o !== 3'b000) begin n_mis++; $display("FAIL reset_rvalid got %b want 000", rvalid_o); end
    n_cmp++; if (err_o !== 3'b000) begin n_mis++; $display("FAIL reset_err got %b want 000", err_o); end
    n_cmp++; if (spurious_o !== 1'b0) begin n_mis++; $display("FAIL reset_spurious got %b want 0", spurious_o); end
    n_cmp++; if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0) begin n_mis++; $display("FAIL reset_idle got req=%b addr=%h want 0/0", mem_req_o, mem_addr_o); end
    tick();
  endtask

  task automatic test_single();
    req_i = '0;
    set_req(0, 32'h0000_0100, 1'b0);
    settle();
    n_cmp++; if (gnt_o !== 3'b001) begin n_mis++; $display("FAIL single_gnt got %b want 001", gnt_o); end
    n_cmp++; if (mem_addr_o !== 32'h100 || mem_we_o !== 1'b0) begin n_mis++; $display("FAIL single_addr got %h/%b want 100/0", mem_addr_o, mem_we_o); end
    tick();
    mem_q[mem_q.size()-1].data = 32'hDEAD_BEEF;
    mem_q[mem_q.size()-1].err  = 1'b0;
    req_i = '0;
    for (int k = 1; k <= RESP_LAT; k++) begin
      settle();
      n_cmp++; if (rvalid_o !== exp_rvalid || err_o !== exp_err) begin n_mis++; $display("FAIL single_rsp k=%0d got %b/%b want %b/%b", k, rvalid_o, err_o, exp_rvalid, exp_err); end
      if (k == RESP_LAT) begin
        n_cmp++; if (rvalid_o !== 3'b001 || rdata_o !== 32'hDEAD_BEEF || err_o !== 3'b000) begin n_mis++; $display("FAIL single_data got %b %h %b want 001 deadbeef 000", rvalid_o, rdata_o, err_o); end
      end
      tick();
    end
  endtask

  task automatic test_contention();
    for (int k = 0; k < 2 * NUM_REQ + RESP_LAT; k++) begin
      req_i = '0;
      if (k < 2 * NUM_REQ) for (int i = 0; i < NUM_REQ; i++) set_req(i, $urandom, 1'b0);
      settle();
      n_cmp++; if (gnt_o !== exp_gnt) begin n_mis++; $display("FAIL contention_gnt k=%0d got %b want %b", k, gnt_o, exp_gnt); end
      n_cmp++; if (rvalid_o !== exp_rvalid || err_o !== exp_err) begin n_mis++; $display("FAIL contention_rsp k=%0d got %b/%b want %b/%b", k, rvalid_o, err_o, exp_rvalid, exp_err); end
      tick();
    end
  endtask

  task automatic test_missing();
    for (int k = 0; k < NUM_REQ + RESP_LAT; k++) begin
      req_i = '0;
      if (k < NUM_REQ) for (int i = 0; i < NUM_REQ; i++) set_req(i, $urandom, 1'b0);
      settle();
      if (exp_win == 1) drop_next = 1'b1;
      n_cmp++; if (rvalid_o !== exp_rvalid || err_o !== exp_err) begin n_mis++; $display("FAIL missing_rsp k=%0d got %b/%b want %b/%b", k, rvalid_o, err_o, exp_rvalid, exp_err); end
      tick();
    end
  endtask

  task automatic test_spurious();
    req_i = '0;
    force_spur = 1'b1;
    settle();
    n_cmp++; if (spurious_o !== 1'b1 || rvalid_o !== 3'b000) begin n_mis++; $display("FAIL spurious_pulse got %b/%b want 1/000", spurious_o, rvalid_o); end
    tick();
    settle();
    n_cmp++; if (spurious_o !== 1'b0) begin n_mis++; $display("FAIL spurious_clear got %b want 0", spurious_o); end
    tick();
  endtask

  task automatic test_reset_mid();
    int guard;
    req_i = '0; set_req(0, $urandom, 1'b0); settle(); tick();
    req_i = '0; set_req(1, $urandom, 1'b0); settle(); tick();
    do_reset(1);
    req_i = '0;
    guard = 0;
    while (mem_q.size() > 0 && guard < 10) begin
      settle();
      n_cmp++; if (rvalid_o !== exp_rvalid || spurious_o !== exp_spur) begin n_mis++; $display("FAIL resetmid_rsp got %b/%b want %b/%b", rvalid_o, spurious_o, exp_rvalid, exp_spur); end
      tick();
      guard++;
    end
    n_cmp++; if (guard >= 10) begin n_mis++; $display("FAIL resetmid_timeout got %0d cycles want < 10", guard); end
    for (int i = 0; i < NUM_REQ; i++) set_req(i, $urandom, 1'b0);
    settle();
    n_cmp++; if (gnt_o !== 3'b001) begin n_mis++; $display("FAIL resetmid_tie got %b want 001", gnt_o); end
    tick();
  endtask

  task automatic test_random();
    last_gnt = '0;
    req_i = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_i[i] || last_gnt[i]) begin
          req_i[i] = ($urandom_range(0, 2) != 0);
          addr_i[i*32 +: 32] = $urandom;
          we_i[i] = 1'($urandom_range(0, 1));
          be_i[i*4 +: 4] = 4'($urandom_range(0, 15));
          wdata_i[i*32 +: 32] = $urandom;
        end
      end
      force_spur = ($urandom_range(0, 15) == 0);
      settle();
      if (exp_win >= 0 && $urandom_range(0, 7) == 0) drop_next = 1'b1;
      last_gnt = exp_gnt;
      n_cmp++; if (gnt_o !== exp_gnt) begin n_mis++; $display("FAIL rand_gnt c=%0d got %b want %b", cyc, gnt_o, exp_gnt); end
      n_cmp++; if (mem_req_o !== exp_mreq || mem_addr_o !== exp_addr || mem_we_o !== exp_we || mem_be_o !== exp_be || mem_wdata_o !== exp_wdata) begin
        n_mis++; $display("FAIL rand_mem c=%0d got %b %h %b %h %h want %b %h %b %h %h", cyc, mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, exp_mreq, exp_addr, exp_we, exp_be, exp_wdata); end
      n_cmp++; if (rvalid_o !== exp_rvalid || err_o !== exp_err || spurious_o !== exp_spur) begin
        n_mis++; $display("FAIL rand_rsp c=%0d got %b/%b/%b want %b/%b/%b", cyc, rvalid_o, err_o, spurious_o, exp_rvalid, exp_err, exp_spur); end
      n_cmp++; if (rdata_o !== mem_rdata_i) begin n_mis++; $display("FAIL rand_rdata c=%0d got %h want %h", cyc, rdata_o, mem_rdata_i); end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; req_i = '0; addr_i = '0; we_i = '0; be_i = '0; wdata_i = '0;
    mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = '0;
    cyc = 0; prio_m = 0; n_cmp = 0; n_mis = 0; drop_next = 1'b0; force_spur = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_contention();
    test_missing();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
